// File: rtl/hilo_muldiv_unit.sv
// Multiply-class execute unit: iterative radix-2 shift-add multiplier that owns
// the HI/LO pair and answers mult, multu, mul, madd and msub with Start/Busy/Done.
module hilo_muldiv_unit #(
   parameter int DATA_W = 32
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic [5:0]        ALUOp,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic              Flush,
   output logic              Busy,
   output logic              Done,
   output logic [DATA_W-1:0] Result,
   output logic [DATA_W-1:0] Hi,
   output logic [DATA_W-1:0] Lo
);

   localparam logic [5:0] OP_MUL   = 6'b000100;
   localparam logic [5:0] OP_MULT  = 6'b000101;
   localparam logic [5:0] OP_MULTU = 6'b000110;
   localparam logic [5:0] OP_MADD  = 6'b000111;
   localparam logic [5:0] OP_MSUB  = 6'b001000;
   localparam int         CNT_W    = $clog2(DATA_W) + 1;

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t                state;
   state_t                nextState;
   logic [2*DATA_W-1:0]   mcand;
   logic [DATA_W:0]       mplier;
   logic [2*DATA_W-1:0]   acc;
   logic [CNT_W-1:0]      cnt;
   logic                  negative;
   logic [5:0]            opReg;

   logic                  validOp;
   logic                  signedOp;
   logic                  accept;
   logic                  lastIter;
   logic [DATA_W:0]       magA;
   logic [DATA_W:0]       magB;
   logic [2*DATA_W-1:0]   product;
   logic [2*DATA_W-1:0]   hiLoSum;
   logic [2*DATA_W-1:0]   hiLoDiff;

   assign validOp  = (ALUOp == OP_MUL) || (ALUOp == OP_MULT) || (ALUOp == OP_MULTU) ||
                     (ALUOp == OP_MADD) || (ALUOp == OP_MSUB);
   assign signedOp = (ALUOp != OP_MULTU);
   assign accept   = (state == IDLE) && Start && !Flush && validOp;
   assign lastIter = (cnt == CNT_W'(DATA_W - 1));

   // Magnitudes carry one extra bit so the most-negative operand survives negation.
   assign magA = (signedOp && A[DATA_W-1]) ? (~{1'b1, A} + {{DATA_W{1'b0}}, 1'b1}) : {1'b0, A};
   assign magB = (signedOp && B[DATA_W-1]) ? (~{1'b1, B} + {{DATA_W{1'b0}}, 1'b1}) : {1'b0, B};

   assign product  = negative ? (~acc + {{(2*DATA_W-1){1'b0}}, 1'b1}) : acc;
   assign hiLoSum  = {Hi, Lo} + product;
   assign hiLoDiff = {Hi, Lo} - product;

   // State register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic: Flush wins over both iteration and completion.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (accept) nextState = RUN;
         end
         RUN: begin
            if (Flush)         nextState = IDLE;
            else if (lastIter) nextState = FINISH;
         end
         FINISH: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Datapath, handshake flags and the architectural HI/LO/Result registers.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Busy     <= 1'b0;
         Done     <= 1'b0;
         Result   <= '0;
         Hi       <= '0;
         Lo       <= '0;
         mcand    <= '0;
         mplier   <= '0;
         acc      <= '0;
         cnt      <= '0;
         negative <= 1'b0;
         opReg    <= '0;
      end else begin
         Busy <= (nextState != IDLE);
         Done <= (state == FINISH) && !Flush;
         if (accept) begin
            mcand    <= {{(DATA_W-1){1'b0}}, magA};
            mplier   <= magB;
            acc      <= '0;
            cnt      <= '0;
            negative <= signedOp && (A[DATA_W-1] ^ B[DATA_W-1]);
            opReg    <= ALUOp;
         end else if ((state == RUN) && !Flush) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
         end else if ((state == FINISH) && !Flush) begin
            case (opReg)
               OP_MULT, OP_MULTU: {Hi, Lo} <= product;
               OP_MADD:           {Hi, Lo} <= hiLoSum;
               OP_MSUB:           {Hi, Lo} <= hiLoDiff;
               OP_MUL:            Result   <= product[DATA_W-1:0];
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Execute-stage responder for the multiply-class ALUOp codes issued by the instruction decoder: mult, multu, mul, madd and msub.
- Owns the architectural HI/LO register pair.
- Runs an iterative radix-2 shift-add multiply with a Start/Busy/Done handshake, so the pipeline stalls on Busy instead of a 32x32 array multiplier sitting in the critical path.

Parameters:
- DATA_W, 32, operand width; HI and LO are each DATA_W bits and the product is 2*DATA_W bits.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request strobe; sampled only in IDLE.
- ALUOp  input  6  operation code: 000101 mult, 000110 multu, 000100 mul, 000111 madd, 001000 msub.
- A  input  DATA_W  rs operand (multiplicand).
- B  input  DATA_W  rt operand (multiplier).
- Flush  input  1  synchronous abort of any in-flight operation.
- Busy  output  1  high while an operation is in flight; pipeline stall request.
- Done  output  1  one-cycle completion pulse.
- Result  output  DATA_W  low word of the product for mul; held until the next mul completes.
- Hi  output  DATA_W  architectural HI register.
- Lo  output  DATA_W  architectural LO register.

Behaviour:
- Reset, asynchronous: state=IDLE; Busy, Done, Result, Hi, Lo, the internal accumulator and the iteration counter all go to 0.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - Accept on a rising edge with Start=1, Flush=0 and ALUOp one of the five codes.
  - On accept, latch |A| and |B|, the signed ops' sign flag (negative = sign(A) XOR sign(B)), the op code, accumulator=0, counter=0; go to RUN; Busy=1.
  - Signed ops (mult, mul, madd, msub): take two's-complement magnitudes. The most-negative operand magnitude is 2^(DATA_W-1), held in DATA_W+1 bits.
  - multu: operands used raw, negative=0.
  - Any other ALUOp with Start=1: ignored; no Busy, no Done, no state change.
- RUN:
  - Each edge: if the multiplier LSB is 1, add the multiplicand to the accumulator; shift the multiplicand left 1 and the multiplier right 1; counter++.
  - After DATA_W iterations go to FINISH.
- FINISH, one edge:
  - P = negative ? -acc : acc (2*DATA_W-bit two's complement).
  - mult/multu: {Hi,Lo}=P.
  - madd: {Hi,Lo}={Hi,Lo}+P, mod 2^(2*DATA_W).
  - msub: {Hi,Lo}={Hi,Lo}-P, mod 2^(2*DATA_W).
  - mul: Result=P[DATA_W-1:0]; Hi/Lo unchanged.
  - Done=1 for exactly one cycle, Busy=0, go to IDLE.
- Latency: acceptance at edge E0. Hi/Lo/Result update and Done rise at edge E(DATA_W+1), i.e. E33 for DATA_W=32. Busy is high from E0 to E33.
- Start while Busy=1 is ignored, including Start coincident with the Done edge. A new request is accepted no earlier than the edge after Done rises.
- Operands A/B may change freely after acceptance; only the latched copies are used.
- Flush=1 on any edge in RUN or FINISH: go to IDLE, Busy=0, no Done, Hi/Lo/Result not written.
- Flush in IDLE blocks a coincident Start.
- Flush has priority over FINISH completion on the same edge.
- Reset mid-operation: immediate return to reset values.
- Hi/Lo/Result change only on a FINISH edge or on reset.

Test Plan:
- Reset: assert Reset asynchronously mid-cycle -> Busy=Done=0 and Hi=Lo=Result=0x00000000 immediately.
- mult, latency and sign: A=0xFFFFFFFD (-3), B=5, Start for one cycle -> Busy for 33 cycles, Done pulses once, Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
- multu: A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
- multu extreme: A=B=0x80000000 -> Hi=0x40000000, Lo=0.
- mult extreme: A=B=0x80000000 -> Hi=0x40000000, Lo=0 (the most-negative magnitude handled correctly).
- madd/msub:
  - Preload Hi:Lo=0:0x10 via mult 4*4, then madd 2*3 -> Hi=0, Lo=0x16.
  - Preload Hi:Lo=0:5, then msub 2*3 -> Hi=Lo=0xFFFFFFFF (borrow crosses the word boundary).
- mul: with Hi:Lo=0x12345678:0x9ABCDEF0, mul 7*0xFFFFFFFE -> Result=0xFFFFFFF2, Hi/Lo unchanged.
- Handshake/abort:
  - Start pulsed at cycle 10 of a busy op -> ignored; exactly one Done.
  - Flush at cycle 20 of a mult -> Busy falls next edge, no Done, Hi/Lo keep prior values.
  - Invalid ALUOp 000001 with Start -> Busy stays 0.
